pipe_hazard_ctrl: RTL and testbench

- Hazard and sequencing controller for the 5-stage RISC-V pipeline (F/D/E/M/W).
- Produces per-stage stall and flush controls for the pipeline registers, and the E-stage operand forwarding selects.
- Handles load-use bubbles, taken-branch flushes and multi-cycle data-memory waits (registered FSM with timeout).
- Keeps saturating performance counters for stall and flush events.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/sat_counter.sv | 20 ++
 rtl/pipe_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

    localparam int unsigned REG_AW = 5;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // Register match that treats x0 as never matching.
    function automatic logic reg_match(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs);
        return (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: stops at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // Count up on inc until the counter is full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: stall/flush sequencing,
// E-stage forwarding selects, data-memory wait with timeout, perf counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic              regwrite_e,
    input  logic              load_e,
    input  logic              pcsrc_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              regwrite_m,
    input  logic              memreq_m,
    input  logic              dmem_ready,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              regwrite_w,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_w,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              mem_err,
    output logic [CNT_W-1:0]  cnt_lu,
    output logic [CNT_W-1:0]  cnt_br,
    output logic [CNT_W-1:0]  cnt_mw
);

    localparam int unsigned TMO_W = 8;

    state_e           state_q;
    state_e           state_d;
    logic [TMO_W-1:0] tmo_q;
    logic [TMO_W-1:0] tmo_d;
    logic             err_d;
    logic             ev_lu;
    logic             ev_br;
    logic             ev_mw;
    logic             mem_release;
    logic             inc_lu;
    logic             inc_br;
    logic             inc_mw;

    // A load is identified by load_e alone; regwrite_e is accepted but not needed.
    logic unused_inputs;
    assign unused_inputs = regwrite_e;

    // Forwarding: M-stage result wins over W-stage result.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        if (regwrite_m && reg_match(rd_m, rs)) begin
            return FWD_M;
        end else if (regwrite_w && reg_match(rd_w, rs)) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

    assign fwd_a_e = fwd_sel(rs1_e);
    assign fwd_b_e = fwd_sel(rs2_e);

    // Hazard events seen this cycle.
    assign ev_lu       = load_e && (reg_match(rd_e, rs1_d) || reg_match(rd_e, rs2_d));
    assign ev_br       = pcsrc_e;
    assign ev_mw       = memreq_m && !dmem_ready;
    assign mem_release = dmem_ready || !memreq_m;

    // State, timeout counter and sticky error register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            tmo_q   <= '0;
            mem_err <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            mem_err <= err_d;
        end
    end

    // Next state and stall/flush controls.
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        err_d   = mem_err;
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        inc_lu  = 1'b0;
        inc_br  = 1'b0;
        inc_mw  = 1'b0;
        case (state_q)
            RUN: begin
                if (ev_mw) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    stall_m = 1'b1;
                    flush_w = 1'b1;
                    state_d = WAIT;
                    tmo_d   = TMO_W'(1);
                end else if (ev_br) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                    inc_br  = 1'b1;
                end else if (ev_lu) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                    inc_lu  = 1'b1;
                end
            end
            WAIT: begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
                inc_mw  = 1'b1;
                if (mem_release) begin
                    // Let the M result move into W on the completing cycle.
                    stall_m = 1'b0;
                    flush_w = 1'b0;
                    state_d = RUN;
                end else if (tmo_q >= TMO_W'(MEM_TIMEOUT)) begin
                    err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt_lu (.clk(clk), .rst(rst), .inc(inc_lu), .cnt(cnt_lu));
    sat_counter #(.CNT_W(CNT_W)) u_cnt_br (.clk(clk), .rst(rst), .inc(inc_br), .cnt(cnt_br));
    sat_counter #(.CNT_W(CNT_W)) u_cnt_mw (.clk(clk), .rst(rst), .inc(inc_mw), .cnt(cnt_mw));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios plus random traffic
// checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned CNT_W       = 2;
    localparam int unsigned MEM_TIMEOUT = 4;
    localparam int          CMAX        = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       regwrite_e, load_e, pcsrc_e, regwrite_m, memreq_m, dmem_ready, regwrite_w;
    logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_err;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic [CNT_W-1:0] cnt_lu, cnt_br, cnt_mw;

    typedef struct {
        int rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
        bit regwrite_e, load_e, pcsrc_e, regwrite_m, memreq_m, dmem_ready, regwrite_w;
        bit rst_n;
    } stim_t;

    typedef struct {
        int sf, sd, se, sm, fd, fe, fw, fa, fb, err, lu, br, mw;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Model state
    bit m_wait;
    int m_wlen;
    bit m_err;
    int m_lu, m_br, m_mw;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .regwrite_e(regwrite_e), .load_e(load_e), .pcsrc_e(pcsrc_e),
        .rd_m(rd_m), .regwrite_m(regwrite_m), .memreq_m(memreq_m), .dmem_ready(dmem_ready),
        .rd_w(rd_w), .regwrite_w(regwrite_w),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .mem_err(mem_err),
        .cnt_lu(cnt_lu), .cnt_br(cnt_br), .cnt_mw(cnt_mw)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // Forward source for one E-stage operand: 2 = M result, 1 = W result, 0 = register file.
    function automatic int fwd_of(input stim_t s, input int rs);
        if (s.regwrite_m && s.rd_m != 0 && s.rd_m == rs) return 2;
        if (s.regwrite_w && s.rd_w != 0 && s.rd_w == rs) return 1;
        return 0;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        s.rst_n = 1'b1;
        return s;
    endfunction

    // Drive one cycle of inputs at the falling edge, record the expected response, step the model.
    task automatic apply(input stim_t s);
        exp_t e;
        bit   mw, br, lu, rel;
        @(negedge clk);
        rst = s.rst_n;
        rs1_d = 5'(s.rs1_d); rs2_d = 5'(s.rs2_d); rs1_e = 5'(s.rs1_e); rs2_e = 5'(s.rs2_e);
        rd_e = 5'(s.rd_e); rd_m = 5'(s.rd_m); rd_w = 5'(s.rd_w);
        regwrite_e = s.regwrite_e; load_e = s.load_e; pcsrc_e = s.pcsrc_e;
        regwrite_m = s.regwrite_m; memreq_m = s.memreq_m; dmem_ready = s.dmem_ready;
        regwrite_w = s.regwrite_w;

        if (!s.rst_n) begin
            m_wait = 0; m_wlen = 0; m_err = 0; m_lu = 0; m_br = 0; m_mw = 0;
        end

        mw  = s.memreq_m && !s.dmem_ready;
        br  = s.pcsrc_e;
        lu  = s.load_e && s.rd_e != 0 && (s.rd_e == s.rs1_d || s.rd_e == s.rs2_d);
        rel = s.dmem_ready || !s.memreq_m;

        e = '{default: 0};
        e.fa = fwd_of(s, s.rs1_e);
        e.fb = fwd_of(s, s.rs2_e);
        e.err = m_err; e.lu = m_lu; e.br = m_br; e.mw = m_mw;
        if (m_wait) begin
            e.sf = 1; e.sd = 1; e.se = 1;
            e.sm = rel ? 0 : 1;
            e.fw = rel ? 0 : 1;
        end else if (mw) begin
            e.sf = 1; e.sd = 1; e.se = 1; e.sm = 1; e.fw = 1;
        end else if (br) begin
            e.fd = 1; e.fe = 1;
        end else if (lu) begin
            e.sf = 1; e.sd = 1; e.fe = 1;
        end
        sb.push_back(e);

        if (s.rst_n) begin
            if (m_wait) begin
                m_mw = sat(m_mw + 1);
                if (rel) begin
                    m_wait = 0;
                end else begin
                    if (m_wlen >= MEM_TIMEOUT) m_err = 1;
                    m_wlen++;
                end
            end else if (mw) begin
                m_wait = 1;
                m_wlen = 1;
            end else if (br) begin
                m_br = sat(m_br + 1);
            end else if (lu) begin
                m_lu = sat(m_lu + 1);
            end
        end
    endtask

    task automatic do_reset();
        stim_t s;
        s = idle();
        s.rst_n = 1'b0;
        apply(s);
    endtask

    // Monitor: compare the DUT against the oldest expectation late in each cycle.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("stall_f", int'(stall_f), e.sf);
                check("stall_d", int'(stall_d), e.sd);
                check("stall_e", int'(stall_e), e.se);
                check("stall_m", int'(stall_m), e.sm);
                check("flush_d", int'(flush_d), e.fd);
                check("flush_e", int'(flush_e), e.fe);
                check("flush_w", int'(flush_w), e.fw);
                check("fwd_a_e", int'(fwd_a_e), e.fa);
                check("fwd_b_e", int'(fwd_b_e), e.fb);
                check("mem_err", int'(mem_err), e.err);
                check("cnt_lu", int'(cnt_lu), e.lu);
                check("cnt_br", int'(cnt_br), e.br);
                check("cnt_mw", int'(cnt_mw), e.mw);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Stimulus: directed scenarios, then random traffic.
    initial begin
        stim_t s;
        rst = 1'b0;
        rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
        regwrite_e = 0; load_e = 0; pcsrc_e = 0; regwrite_m = 0; memreq_m = 0;
        dmem_ready = 0; regwrite_w = 0;

        do_reset();
        #4;
        check("reset_stall_f", int'(stall_f), 0);
        check("reset_cnt_lu", int'(cnt_lu), 0);

        // Forwarding priority and x0
        s = idle();
        s.rs1_e = 5; s.rd_m = 5; s.regwrite_m = 1; s.rd_w = 5; s.regwrite_w = 1;
        apply(s); #4; check("fwd_m_prio", int'(fwd_a_e), 2);
        s.regwrite_m = 0;
        apply(s); #4; check("fwd_w", int'(fwd_a_e), 1);
        s = idle(); s.rs2_e = 0; s.rd_m = 0; s.regwrite_m = 1;
        apply(s); #4; check("fwd_x0", int'(fwd_b_e), 0);

        // Load-use bubble
        do_reset();
        s = idle(); s.load_e = 1; s.rd_e = 7; s.rs2_d = 7;
        apply(s); #4; check("lu_stall_f", int'(stall_f), 1); check("lu_flush_e", int'(flush_e), 1);
        apply(idle()); #4; check("lu_cnt", int'(cnt_lu), 1); check("lu_release", int'(stall_f), 0);

        // Branch beats load-use
        do_reset();
        s = idle(); s.load_e = 1; s.rd_e = 7; s.rs1_d = 7; s.pcsrc_e = 1;
        apply(s); #4; check("br_flush_d", int'(flush_d), 1); check("br_no_stall", int'(stall_f), 0);
        apply(idle()); #4; check("br_cnt", int'(cnt_br), 1); check("br_lu_dropped", int'(cnt_lu), 0);

        // Memory wait, three stalled cycles then ready
        do_reset();
        s = idle(); s.memreq_m = 1;
        repeat (3) apply(s);
        s.dmem_ready = 1;
        apply(s); #4; check("mw_release_stall_m", int'(stall_m), 0); check("mw_release_stall_f", int'(stall_f), 1);
        apply(idle()); #4; check("mw_cnt", int'(cnt_mw), 3); check("mw_run", int'(stall_f), 0);

        // Timeout: RUN cycle plus MEM_TIMEOUT waiting cycles
        do_reset();
        s = idle(); s.memreq_m = 1;
        repeat (1 + MEM_TIMEOUT) apply(s);
        apply(s); #4; check("tmo_err_set", int'(mem_err), 1);
        s.dmem_ready = 1;
        apply(s);
        apply(idle()); #4; check("tmo_err_sticky", int'(mem_err), 1);

        // Asynchronous reset in the middle of a wait
        s = idle(); s.memreq_m = 1;
        apply(s);
        apply(s);
        @(posedge clk); #2;
        rst = 1'b0;
        memreq_m = 0;
        #1;
        check("async_err", int'(mem_err), 0);
        check("async_cnt_mw", int'(cnt_mw), 0);
        check("async_stall", int'(stall_f), 0);
        do_reset();

        // Saturation of the load-use counter
        s = idle(); s.load_e = 1; s.rd_e = 3; s.rs1_d = 3;
        repeat (5) begin
            apply(s);
            apply(idle());
        end
        #4; check("sat_lu", int'(cnt_lu), CMAX);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            s.rs1_d = $urandom_range(0, 3); s.rs2_d = $urandom_range(0, 3);
            s.rs1_e = $urandom_range(0, 3); s.rs2_e = $urandom_range(0, 3);
            s.rd_e  = $urandom_range(0, 3); s.rd_m  = $urandom_range(0, 3);
            s.rd_w  = $urandom_range(0, 3);
            s.regwrite_e = $urandom_range(0, 1);
            s.load_e     = $urandom_range(0, 1);
            s.pcsrc_e    = ($urandom_range(0, 4) == 0);
            s.regwrite_m = $urandom_range(0, 1);
            s.memreq_m   = ($urandom_range(0, 3) != 0);
            s.dmem_ready = ($urandom_range(0, 2) == 0);
            s.regwrite_w = $urandom_range(0, 1);
            s.rst_n      = ($urandom_range(0, 99) != 0);
            apply(s);
        end

        apply(idle());
        @(negedge clk);
        #6;
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
